mem_stage_access_unit: RTL

Memory-stage data access unit of the five-stage RV32I pipeline. Consumes the EX/MEM pipeline register outputs and performs the load or store on a single-outstanding req/ack data bus: byte-lane steering, load sign/zero extension, alignment checking and bus timeout. Stalls the front of the pipeline while an access is in flight, then hands the write-back value, destination and write enable to the MEM/WB register.

---
 rtl/mem_access_pkg.sv | 22 ++
 rtl/mem_stage_access_unit_if.sv | 31 +++
 rtl/load_store_align.sv | 60 ++++++
 rtl/mem_stage_access_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access unit.
// Contents:
//   OP_*                funct3 encodings of the load/store access widths
//   BUS_TIMEOUT_DEFAULT default number of WAIT cycles before a bus abort
//   state_t             access FSM state encoding
package mem_access_pkg;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   localparam int unsigned BUS_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_stage_access_unit_if.sv
// Single-outstanding req/ack data bus between the memory stage and memory.
// Signals:
//   bus_req          access request, held until ack or abort
//   bus_we           1 = write
//   bus_addr         word address
//   bus_wdata        lane-replicated store data
//   bus_byte_enable  active byte lanes
//   bus_rdata        read data, valid with bus_ack
//   bus_ack          one-cycle completion
// Modports: master (the access unit), slave (the memory side).
interface mem_stage_access_unit_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_byte_enable;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_byte_enable,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_byte_enable,
      output bus_rdata, bus_ack
   );

endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for loads and stores.
// Ports:
//   addr_lo_i     address bits [1:0]
//   op_len_i      funct3 access width
//   store_data_i  store data from rs2
//   read_data_i   raw bus read data
//   wdata_o       lane-replicated store data
//   byte_en_o     active byte lanes
//   load_data_o   extracted and extended load value
//   misaligned_o  halfword/word access not naturally aligned
//   illegal_o     op_len_i is not a defined access width
module load_store_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  op_len_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] read_data_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  byte_en_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o,
   output logic        illegal_o
);

   logic [31:0] shifted;

   // Addressed byte moved down to lane 0 before width selection.
   assign shifted = read_data_i >> {addr_lo_i, 3'b000};

   always_comb begin
      wdata_o      = store_data_i;
      byte_en_o    = 4'b1111;
      load_data_o  = shifted;
      misaligned_o = 1'b0;
      illegal_o    = 1'b0;
      case (op_len_i)
         OP_B, OP_BU: begin
            wdata_o     = {4{store_data_i[7:0]}};
            byte_en_o   = 4'b0001 << addr_lo_i;
            load_data_o = (op_len_i == OP_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'd0, shifted[7:0]};
         end
         OP_H, OP_HU: begin
            wdata_o      = {2{store_data_i[15:0]}};
            byte_en_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            load_data_o  = (op_len_i == OP_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'd0, shifted[15:0]};
            misaligned_o = addr_lo_i[0];
         end
         OP_W: begin
            misaligned_o = |addr_lo_i;
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_access_unit.sv
// Memory-stage data access unit of the RV32I pipeline. Performs the load or
// store of the instruction in EX/MEM on a single-outstanding req/ack bus,
// stalls the front of the pipeline while the access is in flight and
// presents the write-back value to MEM/WB.
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   mem_result               effective address or pass-through ALU value
//   mem_rs2_data_forwarded   store data
//   mem_rd, mem_reg_write    destination and its write enable
//   mem_mem_write/read       store / load
//   mem_mem_op_length        funct3 access width
//   bus                      data bus (master side)
//   stall                    hold PC, IF/ID, ID/EX, EX/MEM
//   wb_data, wb_rd           value and destination for MEM/WB
//   wb_reg_write             qualified write enable
//   access_fault             misaligned or illegal access
//   bus_error                timeout abort pulse
module mem_stage_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] mem_result,
   input  logic [31:0] mem_rs2_data_forwarded,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic        mem_mem_write,
   input  logic        mem_mem_read,
   input  logic [2:0]  mem_mem_op_length,
   mem_stage_access_unit_if.master bus,
   output logic        stall,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        access_fault,
   output logic        bus_error
);

   localparam logic [7:0] LAST_WAIT = 8'(BUS_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] load_q, load_d;
   logic        abort_q, abort_d;

   logic [31:0] wdata, load_ext;
   logic [3:0]  byte_en;
   logic        misaligned, illegal;
   logic        any_access, access_ok;
   logic        req, stall_c, fault_c, err_c, wb_we_c;
   logic [31:0] wb_data_c;

   load_store_align u_align (
      .addr_lo_i    (mem_result[1:0]),
      .op_len_i     (mem_mem_op_length),
      .store_data_i (mem_rs2_data_forwarded),
      .read_data_i  (bus.bus_rdata),
      .wdata_o      (wdata),
      .byte_en_o    (byte_en),
      .load_data_o  (load_ext),
      .misaligned_o (misaligned),
      .illegal_o    (illegal)
   );

   assign any_access = mem_mem_read | mem_mem_write;
   assign access_ok  = (mem_mem_read ^ mem_mem_write) & ~illegal & ~misaligned;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      load_d     = load_q;
      abort_d    = abort_q;
      req        = 1'b0;
      stall_c    = 1'b0;
      fault_c    = 1'b0;
      err_c      = 1'b0;
      wb_we_c    = 1'b0;
      wb_data_c  = mem_result;
      case (state_q)
         ST_IDLE: begin
            if (access_ok) begin
               req        = 1'b1;
               stall_c    = 1'b1;
               wait_cnt_d = 8'd0;
               abort_d    = 1'b0;
               if (bus.bus_ack) begin
                  load_d  = load_ext;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (any_access) begin
               fault_c = 1'b1;
            end else begin
               wb_we_c = mem_reg_write;
            end
         end
         ST_WAIT: begin
            stall_c = 1'b1;
            // An ack arriving in the final WAIT cycle still completes the access.
            if (bus.bus_ack) begin
               req     = 1'b1;
               load_d  = load_ext;
               state_d = ST_DONE;
            end else if (wait_cnt_q == LAST_WAIT) begin
               err_c   = 1'b1;
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               req        = 1'b1;
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            wb_data_c = load_q;
            wb_we_c   = mem_reg_write & mem_mem_read & ~abort_q;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 8'd0;
         load_q     <= 32'd0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         load_q     <= load_d;
         abort_q    <= abort_d;
      end
   end

   // Reset forces every output low combinationally, so a reset during WAIT
   // releases the bus and the pipeline in the same cycle.
   assign bus.bus_req         = req & ~reset;
   assign bus.bus_we          = req & ~reset & mem_mem_write;
   assign bus.bus_addr        = (req & ~reset) ? {mem_result[31:2], 2'b00} : 32'd0;
   assign bus.bus_wdata       = (req & ~reset) ? wdata : 32'd0;
   assign bus.bus_byte_enable = (req & ~reset) ? byte_en : 4'd0;

   assign stall        = stall_c & ~reset;
   assign wb_data      = reset ? 32'd0 : wb_data_c;
   assign wb_rd        = reset ? 5'd0 : mem_rd;
   assign wb_reg_write = wb_we_c & ~reset;
   assign access_fault = fault_c & ~reset;
   assign bus_error    = err_c & ~reset;

endmodule
